load_store_unit: RTL

Initiator-side load/store unit between the execute stage and the byte-lane data memory. Accepts one load or store per handshake, converts RISC-V Funct3 width and byte offset into word address, byte enables and lane-rotated write data. Splits accesses that straddle a word boundary into two memory beats. Returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself. The master modport is the execute stage plus the memory.
// Carries no clock or reset; those stay plain ports on the unit.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  mem_en;
  logic                  mem_we;
  logic [DM_ADDRESS-3:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: converts RISC-V width and offset into word beats, with byte enables and lane-rotated data.
// Latency: a memory beat at C+1 and the response at C+2; a split access adds one beat; an illegal request responds at C+1.
// Backpressure: req_ready is low while busy; responses cannot be stalled. The LSU_MISALIGNED_EN macro enables splitting of word-straddling accesses.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);
  localparam int WI = DM_ADDRESS - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [WI-1:0]     mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
`ifdef LSU_MISALIGNED_EN
  logic [3:0]        be_hi_q, be_hi_d;
  logic [DATA_W-1:0] d0_q, d0_d;
`endif

  logic [7:0]          size_mask;
  logic [7:0]          lane_mask;
  logic                req_bad;
  logic [2*DATA_W-1:0] wd_dbl;
  logic [5:0]          rot_base;
  logic [DATA_W-1:0]   wd_rot;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:DM_ADDRESS];

  // Picks the lane of the shifted beat pair at the request offset, then sign- or zero-extends it to the access width.
  function automatic logic [DATA_W-1:0] load_extend(input logic [2*DATA_W-1:0] pair,
                                                    input logic [1:0] off,
                                                    input logic [2:0] f3);
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] r;
    w = pair[{1'b0, off, 3'b000} +: DATA_W];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {{(DATA_W-8){1'b0}}, w[7:0]}   : {{(DATA_W-8){w[7]}}, w[7:0]};
      2'b01:   r = f3[2] ? {{(DATA_W-16){1'b0}}, w[15:0]} : {{(DATA_W-16){w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Decodes the incoming request: byte-lane mask, legality check, and rotated store data.
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'h01;
    endcase
    lane_mask = size_mask << bus.req_addr[1:0];
    req_bad   = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                (bus.req_write && bus.req_funct3[2]);
`ifndef LSU_MISALIGNED_EN
    // Without splitting, a word-straddling access cannot be served.
    req_bad   = req_bad || (lane_mask[7:4] != 4'd0);
`endif
    wd_dbl    = {bus.req_wdata, bus.req_wdata};
    rot_base  = 6'(DATA_W) - {1'b0, bus.req_addr[1:0], 3'b000};
    wd_rot    = wd_dbl[rot_base +: DATA_W];
  end

  // FSM next state. Memory outputs are registered, so each beat is set up one cycle ahead.
  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_be_d     = 4'd0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
`ifdef LSU_MISALIGNED_EN
    be_hi_d      = be_hi_q;
    d0_d         = d0_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          ready_d  = 1'b0;
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          off_d    = bus.req_addr[1:0];
          if (req_bad) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = S_BEAT0;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.req_write;
            mem_addr_d  = bus.req_addr[DM_ADDRESS-1:2];
            mem_be_d    = lane_mask[3:0];
            mem_wdata_d = wd_rot;
`ifdef LSU_MISALIGNED_EN
            be_hi_d     = lane_mask[7:4];
`endif
          end
        end
      end
      S_BEAT0: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = write_q ? '0 : load_extend({{DATA_W{1'b0}}, bus.mem_rdata}, off_q, funct3_q);
`ifdef LSU_MISALIGNED_EN
        // A straddling access first keeps the low word, then issues the next word.
        if (be_hi_q != 4'd0) begin
          state_d      = S_BEAT1;
          resp_valid_d = 1'b0;
          resp_err_d   = resp_err_q;
          resp_rdata_d = resp_rdata_q;
          d0_d         = bus.mem_rdata;
          mem_en_d     = 1'b1;
          mem_we_d     = write_q;
          mem_addr_d   = mem_addr_q + WI'(1);
          mem_be_d     = be_hi_q;
        end
`endif
      end
`ifdef LSU_MISALIGNED_EN
      S_BEAT1: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = write_q ? '0 : load_extend({bus.mem_rdata, d0_q}, off_q, funct3_q);
      end
`endif
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Reset clears all state and aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= '0;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
`ifdef LSU_MISALIGNED_EN
      be_hi_q      <= 4'd0;
      d0_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
`ifdef LSU_MISALIGNED_EN
      be_hi_q      <= be_hi_d;
      d0_q         <= d0_d;
`endif
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
